// File: rtl/up_count_chk_pkg.sv
// rtl/up_count_chk_pkg.sv - shared state type and default widths for the up-counter checker
package up_count_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    RESYNC = 2'd2
  } chk_state_t;

  localparam int DEF_WIDTH  = 5;
  localparam int DEF_PASS_W = 16;
  localparam int DEF_ERR_W  = 8;
  localparam int DEF_RELOCK = 4;

endpackage

// File: rtl/up_count_checker_sat_counter.sv
// rtl/up_count_checker_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/up_count_checker.sv
// rtl/up_count_checker.sv - predicts the next up-counter value each valid cycle and flags deviations
module up_count_checker
  import up_count_chk_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PASS_W = DEF_PASS_W,
  parameter int ERR_W  = DEF_ERR_W,
  parameter int RELOCK = DEF_RELOCK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              cnt_valid,
  input  logic [WIDTH-1:0]  cnt_in,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [PASS_W-1:0] pass_cnt,
  output logic [ERR_W-1:0]  wrap_cnt,
  output logic [WIDTH-1:0]  first_exp,
  output logic [WIDTH-1:0]  first_got
);

  localparam logic [3:0]       RELOCK_L = 4'(RELOCK);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  chk_state_t       state;
  logic [WIDTH-1:0] expected;
  logic [3:0]       good_run;
  logic             captured;

  logic sample, match, pass_inc, err_inc, wrap_inc;

  assign sample   = cnt_valid && !clear;
  assign match    = (cnt_in == expected);
  assign pass_inc = sample && (state != IDLE) && match;
  assign err_inc  = sample && (state != IDLE) && !match;
  assign wrap_inc = pass_inc && (&cnt_in);

  sat_counter #(.W(PASS_W)) u_pass (
    .clk(clk), .reset(reset), .clr(clear), .inc(pass_inc), .cnt(pass_cnt)
  );
  sat_counter #(.W(ERR_W)) u_err (
    .clk(clk), .reset(reset), .clr(clear), .inc(err_inc), .cnt(err_cnt)
  );
  sat_counter #(.W(ERR_W)) u_wrap (
    .clk(clk), .reset(reset), .clr(clear), .inc(wrap_inc), .cnt(wrap_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      expected  <= '0;
      good_run  <= '0;
      captured  <= 1'b0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      first_exp <= '0;
      first_got <= '0;
    end else if (clear) begin
      state     <= IDLE;
      expected  <= '0;
      good_run  <= '0;
      captured  <= 1'b0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      first_exp <= '0;
      first_got <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (cnt_valid) begin
        case (state)
          IDLE: begin
            // The first sample only seeds the prediction.
            expected <= cnt_in + ONE;
            state    <= TRACK;
            locked   <= 1'b1;
          end
          TRACK, RESYNC: begin
            if (match) begin
              expected <= expected + ONE;
              if (state == RESYNC) begin
                if (good_run + 4'd1 == RELOCK_L) begin
                  state    <= TRACK;
                  locked   <= 1'b1;
                  good_run <= '0;
                end else begin
                  good_run <= good_run + 4'd1;
                end
              end
            end else begin
              err_pulse <= 1'b1;
              expected  <= cnt_in + ONE;
              good_run  <= '0;
              state     <= RESYNC;
              locked    <= 1'b0;
              if (err_cnt == '0 && !captured) begin
                captured  <= 1'b1;
                first_exp <= expected;
                first_got <= cnt_in;
              end
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_up_count_checker.sv
// tb/tb_up_count_checker.sv - scoreboard bench for up_count_checker against a behavioural model
module tb_up_count_checker;

  localparam int WIDTH  = 5;
  localparam int PASS_W = 16;
  localparam int ERR_W  = 8;
  localparam int RELOCK = 4;
  localparam int MODV   = 1 << WIDTH;
  localparam int PMAX   = (1 << PASS_W) - 1;
  localparam int EMAX   = (1 << ERR_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              clear = 1'b0;
  logic              cnt_valid = 1'b0;
  logic [WIDTH-1:0]  cnt_in = '0;
  logic              locked;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_cnt;
  logic [PASS_W-1:0] pass_cnt;
  logic [ERR_W-1:0]  wrap_cnt;
  logic [WIDTH-1:0]  first_exp;
  logic [WIDTH-1:0]  first_got;

  up_count_checker #(
    .WIDTH(WIDTH), .PASS_W(PASS_W), .ERR_W(ERR_W), .RELOCK(RELOCK)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .cnt_valid(cnt_valid), .cnt_in(cnt_in),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .pass_cnt(pass_cnt),
    .wrap_cnt(wrap_cnt), .first_exp(first_exp), .first_got(first_got)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lck, pulse, err, pass, wrap, fe, fg;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference: "synced" means a reference sample has been seen; "run" counts matches since the last error.
  bit m_synced, m_tracking, m_captured;
  int m_exp, m_run, m_pass, m_err, m_wrap, m_fe, m_fg, m_pulse;

  task automatic model_reset();
    m_synced = 0; m_tracking = 0; m_captured = 0;
    m_exp = 0; m_run = 0; m_pass = 0; m_err = 0; m_wrap = 0;
    m_fe = 0; m_fg = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit c);
    if (c) begin
      model_reset();
      return;
    end
    m_pulse = 0;
    if (!v) return;
    if (!m_synced) begin
      m_synced = 1; m_tracking = 1; m_exp = (d + 1) % MODV;
    end else if (d == m_exp) begin
      if (m_pass < PMAX) m_pass++;
      if (d == MODV - 1 && m_wrap < EMAX) m_wrap++;
      m_exp = (m_exp + 1) % MODV;
      if (!m_tracking) begin
        m_run++;
        if (m_run >= RELOCK) begin
          m_tracking = 1; m_run = 0;
        end
      end
    end else begin
      m_pulse = 1;
      if (!m_captured) begin
        m_captured = 1; m_fe = m_exp; m_fg = d;
      end
      if (m_err < EMAX) m_err++;
      m_exp = (d + 1) % MODV;
      m_run = 0;
      m_tracking = 0;
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic step(input bit v, input int d, input bit c);
    exp_t e;
    @(negedge clk);
    cnt_valid = v;
    cnt_in    = WIDTH'(d);
    clear     = c;
    model_step(v, d, c);
    e.lck = int'(m_tracking); e.pulse = m_pulse; e.err = m_err; e.pass = m_pass;
    e.wrap = m_wrap; e.fe = m_fe; e.fg = m_fg;
    exp_q.push_back(e);
  endtask

  task automatic feed(input int vals[$]);
    foreach (vals[i]) step(1'b1, vals[i], 1'b0);
  endtask

  // Monitor: compares every cycle's outputs against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("locked", int'(locked), e.lck);
        chk("err_pulse", int'(err_pulse), e.pulse);
        chk("err_cnt", int'(err_cnt), e.err);
        chk("pass_cnt", int'(pass_cnt), e.pass);
        chk("wrap_cnt", int'(wrap_cnt), e.wrap);
        chk("first_exp", int'(first_exp), e.fe);
        chk("first_got", int'(first_got), e.fg);
      end
    end
  end

  initial begin
    int q[$];
    int last;
    int budget;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_locked", int'(locked), 0);
    chk("reset_err_cnt", int'(err_cnt), 0);
    chk("reset_pass_cnt", int'(pass_cnt), 0);
    chk("reset_wrap_cnt", int'(wrap_cnt), 0);
    chk("reset_first", int'(first_exp) + int'(first_got), 0);
    reset = 1'b1;

    // Clean stream with one wrap
    q = {};
    for (int i = 0; i < 34; i++) q.push_back(i % MODV);
    step(1'b1, q[0], 1'b0);
    q.delete(0);
    @(posedge clk); #1;
    chk("lock_after_first", int'(locked), 1);
    feed(q);
    step(1'b0, 0, 1'b0);
    chk("clean_pass", int'(pass_cnt), 33);
    chk("clean_wrap", int'(wrap_cnt), 1);
    chk("clean_err", int'(err_cnt), 0);

    // Single glitch, relock after RELOCK matches
    step(1'b0, 0, 1'b1);
    feed('{5, 6, 7, 9});
    step(1'b0, 0, 1'b0);
    chk("glitch_locked", int'(locked), 0);
    chk("glitch_first_exp", int'(first_exp), 8);
    chk("glitch_first_got", int'(first_got), 9);
    feed('{10, 11, 12, 13});
    step(1'b0, 0, 1'b0);
    chk("glitch_relock", int'(locked), 1);
    chk("glitch_pass", int'(pass_cnt), 6);
    chk("glitch_err", int'(err_cnt), 1);

    // Gapped valid
    step(1'b0, 0, 1'b1);
    feed('{3, 4});
    repeat (5) step(1'b0, $urandom_range(0, MODV - 1), 1'b0);
    feed('{5, 6});
    step(1'b0, 0, 1'b0);
    chk("gap_pass", int'(pass_cnt), 3);
    chk("gap_err", int'(err_cnt), 0);

    // Repeated errors while resynchronising
    step(1'b0, 0, 1'b1);
    feed('{0, 1, 7, 7, 7, 8});
    step(1'b0, 0, 1'b0);
    chk("repeat_locked", int'(locked), 0);

    // Error counter saturation
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 302; i++) step(1'b1, (i % 2) ? 5 : 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("sat_err", int'(err_cnt), EMAX);
    chk("sat_first_exp", int'(first_exp), 1);
    chk("sat_first_got", int'(first_got), 5);

    // Clear coincident with a valid sample during resync
    step(1'b0, 0, 1'b1);
    feed('{0, 1, 9});
    step(1'b1, 10, 1'b1);
    step(1'b0, 0, 1'b0);
    chk("clear_locked", int'(locked), 0);
    chk("clear_err", int'(err_cnt), 0);
    chk("clear_first_got", int'(first_got), 0);
    feed('{12, 13});
    step(1'b0, 0, 1'b0);
    chk("clear_relock", int'(locked), 1);
    chk("clear_relock_pass", int'(pass_cnt), 1);

    // Randomized mostly-counting stream with glitches, gaps and clears
    last = 0;
    for (int i = 0; i < 3000; i++) begin
      bit v, c;
      int d;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 199) == 0);
      d = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, MODV - 1)) : (last + 1) % MODV;
      if (v) last = d;
      step(v, d, c);
    end
    step(1'b0, 0, 1'b0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
